// File: rtl/mnist_argmax_unit.sv
// Sequential argmax over packed Q8.8 class scores: captures on a done edge, scans one
// class per cycle, and holds {digit, score} on a valid/ready result port until accepted.
module mnist_argmax_unit #(
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned SCORE_W     = 16,
    parameter int unsigned IDX_W       = 4,
    parameter int unsigned SIGNED_CMP  = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CLASSES*SCORE_W-1:0] scores_in,
    input  logic                           scores_done,
    output logic [IDX_W-1:0]               result_digit,
    output logic [SCORE_W-1:0]             result_score,
    output logic                           result_valid,
    input  logic                           result_ready,
    output logic                           busy,
    output logic                           overrun,
    input  logic                           overrun_clr
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_HOLD
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t               state_q, state_d;
    logic                 done_q;
    logic [SCORE_W-1:0]   buf_q [NUM_CLASSES];
    logic [SCORE_W-1:0]   buf_d [NUM_CLASSES];
    logic [SCORE_W-1:0]   max_q, max_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     res_digit_q, res_digit_d;
    logic [SCORE_W-1:0]   res_score_q, res_score_d;
    logic                 res_valid_q, res_valid_d;
    logic                 overrun_q, overrun_d;

    logic                 start_evt;
    logic                 xfer;
    logic                 capture;
    logic                 drop;
    logic [SCORE_W-1:0]   cand;
    logic                 cand_ge;
    logic [SCORE_W-1:0]   score_in [NUM_CLASSES];

    // Ties resolve toward the later (higher) class index, hence >=.
    function automatic logic score_ge(input logic [SCORE_W-1:0] a,
                                      input logic [SCORE_W-1:0] b);
        if (SIGNED_CMP != 0) begin
            return $signed(a) >= $signed(b);
        end
        return a >= b;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
            score_in[i] = scores_in[i*SCORE_W +: SCORE_W];
        end
    end

    assign start_evt = scores_done & ~done_q;
    assign xfer      = res_valid_q & result_ready;
    assign capture   = start_evt & ((state_q == ST_IDLE) | ((state_q == ST_HOLD) & xfer));
    assign drop      = start_evt & ~capture;
    assign cand      = buf_q[ptr_q];
    assign cand_ge   = score_ge(cand, max_q);

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        max_d       = max_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        res_digit_d = res_digit_q;
        res_score_d = res_score_q;

        unique case (state_q)
            ST_SCAN: begin
                if (cand_ge) begin
                    max_d = cand;
                    idx_d = ptr_q;
                end
                ptr_d = ptr_q + IDX_W'(1);
                if (ptr_q == LAST_IDX) begin
                    state_d     = ST_HOLD;
                    res_digit_d = cand_ge ? ptr_q : idx_q;
                    res_score_d = cand_ge ? cand : max_q;
                end
            end
            ST_HOLD: begin
                if (xfer) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        // A capture overrides the HOLD->IDLE exit so a done edge coinciding with
        // the handshake starts the next scan without passing through IDLE.
        if (capture) begin
            buf_d = score_in;
            max_d = score_in[0];
            idx_d = '0;
            ptr_d = IDX_W'(1);
            if (NUM_CLASSES == 1) begin
                state_d     = ST_HOLD;
                res_digit_d = '0;
                res_score_d = score_in[0];
            end else begin
                state_d = ST_SCAN;
            end
        end

        res_valid_d = (state_d == ST_HOLD);

        if (drop) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            done_q      <= 1'b0;
            buf_q       <= '{default: '0};
            max_q       <= '0;
            idx_q       <= '0;
            ptr_q       <= '0;
            res_digit_q <= '0;
            res_score_q <= '0;
            res_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_q      <= scores_done;
            buf_q       <= buf_d;
            max_q       <= max_d;
            idx_q       <= idx_d;
            ptr_q       <= ptr_d;
            res_digit_q <= res_digit_d;
            res_score_q <= res_score_d;
            res_valid_q <= res_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign result_digit = res_digit_q;
    assign result_score = res_score_q;
    assign result_valid = res_valid_q;
    assign busy         = (state_q != ST_IDLE);
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_mnist_argmax_unit.sv
// Directed bench for mnist_argmax_unit: default signed instance, an unsigned-compare
// instance and a single-class instance, all checked against hand-computed results.
module tb_mnist_argmax_unit;

    logic         clk;
    logic         rst;
    logic [159:0] scores_in;
    logic         done_a, done_b, done_c;
    logic         result_ready;
    logic         overrun_clr;

    logic [3:0]   digit_a, digit_b;
    logic [0:0]   digit_c;
    logic [15:0]  score_a, score_b, score_c;
    logic         valid_a, valid_b, valid_c;
    logic         busy_a, busy_b, busy_c;
    logic         ovr_a, ovr_b, ovr_c;

    int checks = 0;
    int errors = 0;

    mnist_argmax_unit #(.NUM_CLASSES(10), .SCORE_W(16), .IDX_W(4), .SIGNED_CMP(1)) u_sgn (
        .clk(clk), .rst(rst), .scores_in(scores_in), .scores_done(done_a),
        .result_digit(digit_a), .result_score(score_a), .result_valid(valid_a),
        .result_ready(result_ready), .busy(busy_a), .overrun(ovr_a), .overrun_clr(overrun_clr)
    );

    mnist_argmax_unit #(.NUM_CLASSES(10), .SCORE_W(16), .IDX_W(4), .SIGNED_CMP(0)) u_uns (
        .clk(clk), .rst(rst), .scores_in(scores_in), .scores_done(done_b),
        .result_digit(digit_b), .result_score(score_b), .result_valid(valid_b),
        .result_ready(result_ready), .busy(busy_b), .overrun(ovr_b), .overrun_clr(overrun_clr)
    );

    mnist_argmax_unit #(.NUM_CLASSES(1), .SCORE_W(16), .IDX_W(1), .SIGNED_CMP(1)) u_one (
        .clk(clk), .rst(rst), .scores_in(scores_in[15:0]), .scores_done(done_c),
        .result_digit(digit_c), .result_score(score_c), .result_valid(valid_c),
        .result_ready(result_ready), .busy(busy_c), .overrun(ovr_c), .overrun_clr(overrun_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_all(input logic [15:0] v);
        for (int i = 0; i < 10; i++) scores_in[i*16 +: 16] = v;
    endtask

    task automatic set_sc(input int i, input logic [15:0] v);
        scores_in[i*16 +: 16] = v;
    endtask

    task automatic pulse(input logic a, input logic b);
        @(negedge clk);
        done_a = a;
        done_b = b;
        @(negedge clk);
        done_a = 1'b0;
        done_b = 1'b0;
    endtask

    // Counts negedges until valid_a rises; bounded so a stuck DUT still reaches the summary.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!valid_a && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int n;
        rst = 1'b1;
        scores_in = '0;
        done_a = 1'b0; done_b = 1'b0; done_c = 1'b0;
        result_ready = 1'b0;
        overrun_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_digit", digit_a, 0);
        chk("rst_score", score_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_ovr", ovr_a, 0);
        rst = 1'b0;

        // basic: class 7 wins, 9-cycle latency, single transfer
        result_ready = 1'b1;
        set_all(16'h0100);
        set_sc(7, 16'h0480);
        pulse(1'b1, 1'b0);
        chk("t1_busy", busy_a, 1);
        wait_valid(cyc);
        chk("t1_lat", cyc, 9);
        chk("t1_digit", digit_a, 7);
        chk("t1_score", score_a, 16'h0480);
        @(negedge clk);
        chk("t1_vdrop", valid_a, 0);
        chk("t1_idle", busy_a, 0);
        chk("t1_keep", digit_a, 7);
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (valid_a) n++;
        end
        chk("t1_once", n, 0);

        // ties go to higher index
        set_all(16'h0100);
        set_sc(2, 16'h0300);
        set_sc(5, 16'h0300);
        pulse(1'b1, 1'b0);
        wait_valid(cyc);
        chk("t2_digit", digit_a, 5);
        chk("t2_score", score_a, 16'h0300);
        set_all(16'h0000);
        pulse(1'b1, 1'b0);
        wait_valid(cyc);
        chk("t2_zero_digit", digit_a, 9);
        chk("t2_zero_score", score_a, 0);

        // signed vs unsigned compare
        set_all(16'h8000);
        set_sc(0, 16'hFF00);
        set_sc(3, 16'h0000);
        pulse(1'b1, 1'b0);
        wait_valid(cyc);
        chk("t3_sgn_digit", digit_a, 3);
        chk("t3_sgn_score", score_a, 0);
        set_all(16'h0100);
        set_sc(0, 16'h7FFF);
        set_sc(1, 16'h8000);
        pulse(1'b1, 1'b1);
        wait_valid(cyc);
        chk("t3_s_digit", digit_a, 0);
        chk("t3_s_score", score_a, 16'h7FFF);
        chk("t3_u_valid", valid_b, 1);
        chk("t3_u_digit", digit_b, 1);
        chk("t3_u_score", score_b, 16'h8000);

        // single class: capture goes straight to HOLD
        @(negedge clk);
        set_sc(0, 16'h1234);
        done_c = 1'b1;
        @(negedge clk);
        done_c = 1'b0;
        chk("t_one_valid", valid_c, 1);
        chk("t_one_digit", digit_c, 0);
        chk("t_one_score", score_c, 16'h1234);
        @(negedge clk);
        chk("t_one_vdrop", valid_c, 0);

        // backpressure in HOLD, dropped event, overrun clear priority
        result_ready = 1'b0;
        set_all(16'h0100);
        set_sc(4, 16'h0200);
        pulse(1'b1, 1'b0);
        wait_valid(cyc);
        chk("t4_digit0", digit_a, 4);
        set_sc(8, 16'h0700);
        pulse(1'b1, 1'b0);
        repeat (18) @(negedge clk);
        chk("t4_valid", valid_a, 1);
        chk("t4_digit", digit_a, 4);
        chk("t4_score", score_a, 16'h0200);
        chk("t4_ovr", ovr_a, 1);
        overrun_clr = 1'b1;
        done_a = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        done_a = 1'b0;
        chk("t4_clr_vs_drop", ovr_a, 1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        chk("t4_clr", ovr_a, 0);
        result_ready = 1'b1;
        @(negedge clk);
        chk("t4_taken", valid_a, 0);
        chk("t4_idle", busy_a, 0);
        chk("t4_kept_digit", digit_a, 4);
        chk("t4_kept_score", score_a, 16'h0200);

        // level done gives one result; done edge on handshake starts new scan
        set_all(16'h0100);
        set_sc(1, 16'h0250);
        @(negedge clk);
        done_a = 1'b1;
        n = 0;
        repeat (50) begin
            @(negedge clk);
            if (valid_a) n++;
        end
        done_a = 1'b0;
        chk("t5_one_result", n, 1);
        chk("t5_digit", digit_a, 1);
        result_ready = 1'b0;
        set_sc(2, 16'h0300);
        pulse(1'b1, 1'b0);
        wait_valid(cyc);
        chk("t5_hold_digit", digit_a, 2);
        set_all(16'h0100);
        set_sc(0, 16'h0500);
        done_a = 1'b1;
        result_ready = 1'b1;
        @(negedge clk);
        done_a = 1'b0;
        chk("t5_rescan_busy", busy_a, 1);
        chk("t5_rescan_valid", valid_a, 0);
        chk("t5_rescan_ovr", ovr_a, 0);
        wait_valid(cyc);
        chk("t5_lat", cyc, 9);
        chk("t5_new_digit", digit_a, 0);
        chk("t5_new_score", score_a, 16'h0500);

        // drop during SCAN, then async reset mid-scan
        set_all(16'h0000);
        set_sc(3, 16'h0333);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        chk("t6_scan_drop", ovr_a, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", valid_a, 0);
        chk("t6_rst_busy", busy_a, 0);
        chk("t6_rst_digit", digit_a, 0);
        chk("t6_rst_score", score_a, 0);
        chk("t6_rst_ovr", ovr_a, 0);
        @(negedge clk);
        rst = 1'b0;
        set_all(16'h0100);
        set_sc(6, 16'h0600);
        pulse(1'b1, 1'b0);
        wait_valid(cyc);
        chk("t6_lat", cyc, 9);
        chk("t6_digit", digit_a, 6);
        chk("t6_score", score_a, 16'h0600);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
